instr_encoder: RTL

- Encoder counterpart to the immediate generator in the execute path.
- Packs decoded fields (operation class, registers, funct3, signed offset) into a 32-bit RV32I LOAD, STORE or BRANCH instruction word.
- Used by the self-test instruction injector and by power-modeling stimulus generation.
- Two-stage valid/ready pipeline: range-checks the offset, flags unencodable requests, and keeps saturating activity counters.

---
 rtl/instr_encoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I LOAD/STORE/BRANCH instruction encoder: two-stage valid/ready pipeline
// with offset range checking and saturating delivery counters.
module instr_encoder #(
  parameter  int unsigned CNT_WIDTH         = 16,
  localparam int unsigned INSTR_WIDTH       = 32,
  localparam int unsigned RISC_V_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [2:0]                   in_funct3,
  input  logic [RISC_V_DATA_WIDTH-1:0] in_offset,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic                         out_err,
  output logic [CNT_WIDTH-1:0]         enc_count,
  output logic [CNT_WIDTH-1:0]         err_count
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_STORE  = 2'd1,
    OP_BRANCH = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef struct packed {
    logic [1:0]                   op;
    logic [4:0]                   rd;
    logic [4:0]                   rs1;
    logic [4:0]                   rs2;
    logic [2:0]                   funct3;
    logic [RISC_V_DATA_WIDTH-1:0] offset;
  } req_t;

  logic                   s1_valid_q, s1_valid_d;
  req_t                   s1_req_q, s1_req_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
  logic                   out_err_q, out_err_d;
  logic [CNT_WIDTH-1:0]   enc_count_q, enc_count_d;
  logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;

  logic                   s1_adv;
  logic                   accept;
  logic                   out_hs;
  logic [INSTR_WIDTH-1:0] enc_instr_c;
  logic                   enc_err_c;
  logic                   ld_st_ok;
  logic                   br_ok;
  logic signed [RISC_V_DATA_WIDTH-1:0] off_s;

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign out_hs   = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

  // Encode the stage-1 request; any unencodable request yields an all-zero word.
  always_comb begin
    off_s       = $signed(s1_req_q.offset);
    ld_st_ok    = (off_s >= -32'sd2048) && (off_s <= 32'sd2047);
    br_ok       = (off_s >= -32'sd4096) && (off_s <= 32'sd4094) && !s1_req_q.offset[0];
    enc_instr_c = '0;
    enc_err_c   = 1'b0;
    case (op_e'(s1_req_q.op))
      OP_LOAD: begin
        enc_err_c   = !ld_st_ok;
        enc_instr_c = {s1_req_q.offset[11:0], s1_req_q.rs1, s1_req_q.funct3,
                       s1_req_q.rd, OPC_LOAD};
      end
      OP_STORE: begin
        enc_err_c   = !ld_st_ok;
        enc_instr_c = {s1_req_q.offset[11:5], s1_req_q.rs2, s1_req_q.rs1,
                       s1_req_q.funct3, s1_req_q.offset[4:0], OPC_STORE};
      end
      OP_BRANCH: begin
        enc_err_c   = !br_ok;
        enc_instr_c = {s1_req_q.offset[12], s1_req_q.offset[10:5], s1_req_q.rs2,
                       s1_req_q.rs1, s1_req_q.funct3, s1_req_q.offset[4:1],
                       s1_req_q.offset[11], OPC_BRANCH};
      end
      default: begin
        enc_err_c   = 1'b1;
      end
    endcase
    if (enc_err_c) begin
      enc_instr_c = '0;
    end
  end

  // Pipeline advance and counter next-state.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_req_d    = s1_req_q;
    s2_valid_d  = s2_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_req_d   = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                     funct3: in_funct3, offset: in_offset};
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // A stage-1 advance overwrites stage 2 even when it is handing off this cycle.
    if (s1_adv) begin
      s2_valid_d  = 1'b1;
      out_instr_d = enc_instr_c;
      out_err_d   = enc_err_c;
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end

    if (out_hs) begin
      if (out_err_q) begin
        if (err_count_q != '1) err_count_d = err_count_q + CNT_WIDTH'(1);
      end else begin
        if (enc_count_q != '1) enc_count_d = enc_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s2_valid_q  <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      s2_valid_q  <= s2_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

endmodule
